// File: rtl/gate_tt_pkg.sv
// Shared encodings for the gate truth-table checker: gate selects, FSM states, row counts
// and row-to-pin mapping helpers.
package gate_tt_pkg;

   localparam logic [2:0] GS_AND2 = 3'd0;
   localparam logic [2:0] GS_OR2  = 3'd1;
   localparam logic [2:0] GS_NAND2 = 3'd2;
   localparam logic [2:0] GS_NOR2 = 3'd3;
   localparam logic [2:0] GS_INV  = 3'd4;

   localparam int unsigned ROWS_2IN = 4;
   localparam int unsigned ROWS_INV = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SAMPLE,
      ST_DONE
   } state_e;

   function automatic logic sel_legal(input logic [2:0] sel);
      return (sel <= GS_INV);
   endfunction

   function automatic logic [1:0] last_row(input logic [2:0] sel);
      return (sel == GS_INV) ? 2'(ROWS_INV - 1) : 2'(ROWS_2IN - 1);
   endfunction

   // Returns {a, b} for row v; INV drives its single input from v[0] and parks b low.
   function automatic logic [1:0] row_ab(input logic [2:0] sel, input logic [1:0] v);
      return (sel == GS_INV) ? {v[0], 1'b0} : v;
   endfunction

endpackage

// File: rtl/gate_tt_checker_if.sv
// Gate pin interface: the checker (master) drives a/b and reads f; the cell under test is the slave.
interface gate_tt_checker_if;
   logic dut_a;
   logic dut_b;
   logic dut_f;

   modport master (output dut_a, output dut_b, input dut_f);
   modport slave  (input dut_a, input dut_b, output dut_f);
endinterface

// File: rtl/gate_tt_ref.sv
// Combinational golden model of the library gate cells (AND2, OR2, NAND2, NOR2, INV).
module gate_tt_ref
   import gate_tt_pkg::*;
(
   input  logic [2:0] sel,
   input  logic       a,
   input  logic       b,
   output logic       exp_f
);

   always_comb begin
      exp_f = 1'b0;
      unique case (sel)
         GS_AND2:  exp_f = a & b;
         GS_OR2:   exp_f = a | b;
         GS_NAND2: exp_f = ~(a & b);
         GS_NOR2:  exp_f = ~(a | b);
         GS_INV:   exp_f = ~a;
         default:  exp_f = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table sweeper/checker for the 2-input gate cells and INV.
// Optional raw-sample capture port f_capture is enabled with macro GATE_TT_CAPTURE_EN.
module gate_tt_checker
   import gate_tt_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           gate_sel,
   gate_tt_checker_if.master    gate_if,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [3:0]           fail_vec,
   output logic [ERR_W-1:0]     err_count,
   output logic                 bad_sel
`ifdef GATE_TT_CAPTURE_EN
   ,
   output logic [3:0]           f_capture
`endif
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e            r_state, n_state;
   logic [1:0]        r_v, n_v;
   logic [CNT_W-1:0]  r_cnt, n_cnt;
   logic [2:0]        r_sel, n_sel;
   logic              r_a, n_a, r_b, n_b;
   logic              r_busy, n_busy, r_done, n_done;
   logic              r_pass, n_pass, r_bad, n_bad;
   logic [3:0]        r_fail, n_fail;
   logic [ERR_W-1:0]  r_err, n_err;
`ifdef GATE_TT_CAPTURE_EN
   logic [3:0]        r_cap, n_cap;
`endif
   logic              w_exp;

   gate_tt_ref u_ref (
      .sel   (r_sel),
      .a     (r_a),
      .b     (r_b),
      .exp_f (w_exp)
   );

   // Outputs are registered on the transition into the state that owns them,
   // so busy/done/pass/pins are already valid in the first cycle of that state.
   always_comb begin
      n_state = r_state;
      n_v     = r_v;
      n_cnt   = r_cnt;
      n_sel   = r_sel;
      n_a     = r_a;
      n_b     = r_b;
      n_busy  = 1'b0;
      n_done  = 1'b0;
      n_pass  = r_pass;
      n_fail  = r_fail;
      n_err   = r_err;
      n_bad   = r_bad;
`ifdef GATE_TT_CAPTURE_EN
      n_cap   = r_cap;
`endif
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               n_pass = 1'b0;
               n_err  = '0;
               n_v    = '0;
               n_cnt  = '0;
`ifdef GATE_TT_CAPTURE_EN
               n_cap  = '0;
`endif
               if (sel_legal(gate_sel)) begin
                  n_sel      = gate_sel;
                  n_fail     = '0;
                  n_bad      = 1'b0;
                  {n_a, n_b} = row_ab(gate_sel, 2'd0);
                  n_busy     = 1'b1;
                  n_state    = ST_DRIVE;
               end else begin
                  n_fail  = '1;
                  n_bad   = 1'b1;
                  n_done  = 1'b1;
                  n_state = ST_DONE;
               end
            end
         end
         ST_DRIVE: begin
            n_busy = 1'b1;
            if (r_cnt == CNT_LAST) begin
               n_cnt   = '0;
               n_state = ST_SAMPLE;
            end else begin
               n_cnt = r_cnt + CNT_W'(1);
            end
         end
         ST_SAMPLE: begin
            if (gate_if.dut_f != w_exp) begin
               n_fail[r_v] = 1'b1;
               if (r_err != '1) n_err = r_err + ERR_W'(1);
            end
`ifdef GATE_TT_CAPTURE_EN
            n_cap[r_v] = gate_if.dut_f;
`endif
            if (r_v == last_row(r_sel)) begin
               n_a     = 1'b0;
               n_b     = 1'b0;
               n_done  = 1'b1;
               n_pass  = (n_fail == '0) && !r_bad;
               n_state = ST_DONE;
            end else begin
               n_v        = r_v + 2'd1;
               {n_a, n_b} = row_ab(r_sel, r_v + 2'd1);
               n_busy     = 1'b1;
               n_state    = ST_DRIVE;
            end
         end
         ST_DONE: n_state = ST_IDLE;
         default: n_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_v     <= '0;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_fail  <= '0;
         r_err   <= '0;
         r_bad   <= 1'b0;
`ifdef GATE_TT_CAPTURE_EN
         r_cap   <= '0;
`endif
      end else begin
         r_state <= n_state;
         r_v     <= n_v;
         r_cnt   <= n_cnt;
         r_sel   <= n_sel;
         r_a     <= n_a;
         r_b     <= n_b;
         r_busy  <= n_busy;
         r_done  <= n_done;
         r_pass  <= n_pass;
         r_fail  <= n_fail;
         r_err   <= n_err;
         r_bad   <= n_bad;
`ifdef GATE_TT_CAPTURE_EN
         r_cap   <= n_cap;
`endif
      end
   end

   assign gate_if.dut_a = r_a;
   assign gate_if.dut_b = r_b;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign fail_vec      = r_fail;
   assign err_count     = r_err;
   assign bad_sel       = r_bad;
`ifdef GATE_TT_CAPTURE_EN
   assign f_capture     = r_cap;
`endif

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Sequential exerciser and checker for the team's 2-input gate cells (AND2, OR2, NAND2, NOR2) and the INV cell.
- Drives the inputs of a device under test (DUT), sweeps the truth table, samples the DUT output and compares each row against a golden model.
- Reports pass/fail per row.
- Sits beside the gate library on the lab board or in the bench: the driving/checking end of the gate interface.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each input vector is held before f is sampled; minimum 1.
- ERR_W, 3, width of the error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  begin a sweep; sampled only in IDLE.
- gate_sel  input  3  gate under test: 0 AND2, 1 OR2, 2 NAND2, 3 NOR2, 4 INV; 5-7 illegal.
- dut_f  input  1  DUT output f.
- dut_a  output  1  DUT input a.
- dut_b  output  1  DUT input b; held 0 for INV.
- busy  output  1  high from the cycle after accepted start until DONE.
- done  output  1  one-cycle pulse at the end of a sweep.
- pass  output  1  1 when all rows matched; valid from done until the next accepted start.
- fail_vec  output  4  bit v set when row v mismatched.
- err_count  output  ERR_W  number of mismatching rows.
- bad_sel  output  1  set when the sweep was aborted for an illegal gate_sel.

Behaviour:
- Reset values: all outputs 0; FSM enters IDLE; vector index v=0; settle counter=0.
- gate_sel latching: captured on the accepted start; later changes are ignored until the next sweep.
- Row encoding: row v applies dut_a=v[1], dut_b=v[0]. INV uses rows 0 and 1 only, with dut_a=v[0] and dut_b=0.
- Row counts: 4 rows for the 2-input gates, 2 rows for INV.

FSM:
- IDLE: on start=1 with a legal gate_sel:
  - clear pass, fail_vec, err_count and bad_sel;
  - set v=0, busy=1, drive row 0;
  - go to DRIVE.
- IDLE: on start=1 with an illegal gate_sel:
  - set bad_sel=1, pass=0, fail_vec=4'hF;
  - go to DONE; busy stays 0.
- DRIVE: hold the row for SETTLE_CYCLES cycles, counting 0..SETTLE_CYCLES-1, then go to SAMPLE.
- SAMPLE (one cycle): compare dut_f with the golden value.
  - On mismatch: set fail_vec[v]; increment err_count, saturating at all-ones.
  - If v is the last row, go to DONE. Otherwise v=v+1, drive the next row and go to DRIVE.
- DONE (one cycle):
  - done=1, busy=0;
  - pass=1 iff fail_vec==0 and bad_sel==0;
  - dut_a and dut_b return to 0;
  - go to IDLE.

Timing:
- dut_a/dut_b are registered and change only on entry to DRIVE.
- Latency from accepted start to the done pulse is rows*(SETTLE_CYCLES+1)+1 cycles:
  - 13 cycles for 2-input gates with the default SETTLE_CYCLES;
  - 7 cycles for INV.

Boundary cases:
- start while busy, or during DONE: ignored.
- start held high continuously: a new sweep begins on the cycle after DONE.
- err_count saturates; it cannot wrap even for ERR_W<3.
- rst_n asserted mid-sweep: immediate asynchronous return to reset values. No done pulse; partial results are discarded.

Optional Feature:
- Macro: GATE_TT_CAPTURE_EN.
- Defined: adds output port f_capture, 4 bits. Bit v holds the raw dut_f sampled in row v. Unused rows read 0. It is cleared on accepted start and valid with done.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Package gate_tt_pkg:
  - gate_sel encodings as named constants (GS_AND2..GS_INV);
  - FSM state encodings;
  - ROWS_2IN=4 and ROWS_INV=2.
- Sub-module gate_tt_ref: combinational golden model with inputs sel, a, b and output exp_f. It must implement exactly the library gate functions.

Test Plan:
- gate_sel=0, DUT is a real AND2, start pulse → done 13 cycles later; pass=1, fail_vec=0000, err_count=0.
- gate_sel=2 with a NOR2 wired as DUT → rows 1 and 2 mismatch; fail_vec=0110, err_count=2, pass=0.
- gate_sel=4, INV DUT, dut_b observed 0 throughout → done after 7 cycles, pass=1. A stuck-at-0 DUT instead gives fail_vec=0001.
- gate_sel=6, start → next cycle DONE: done=1, bad_sel=1, fail_vec=1111, pass=0, busy never high.
- rst_n pulled low while in the third DRIVE state (v=2) → all outputs 0 asynchronously, no done pulse; a fresh start after release completes a normal sweep.
- Second start pulses during busy, plus a gate_sel change mid-sweep → ignored. The result matches the latched gate; exactly one done pulse.
